// File: rtl/dual_stack_pkg.sv
// Shared types and constants for the dual_stack scheduler slice.
package dual_stack_pkg;

  localparam int STACK_WORDS = 16;
  localparam int DATA_W      = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_t;

  typedef enum logic {
    POP  = 1'b0,
    PUSH = 1'b1
  } stack_op_t;

endpackage

// File: rtl/dual_stack_sched_arb.sv
// Two-way request arbiter with last-grant pointer.
// DUAL_STACK_SCHED_FIXED_PRIO_EN selects fixed priority (requester 0 wins ties, no pointer).
module dual_stack_sched_arb (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic req0_valid_i,
  input  logic req1_valid_i,
  output logic gnt0_o,
  output logic gnt1_o
);

`ifdef DUAL_STACK_SCHED_FIXED_PRIO_EN
  logic unused_clkrst;
  assign unused_clkrst = clk ^ rst_n;

  assign gnt0_o = en_i & req0_valid_i;
  assign gnt1_o = en_i & req1_valid_i & ~req0_valid_i;
`else
  logic last_q, last_d;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    gnt0_o = 1'b0;
    gnt1_o = 1'b0;
    if (en_i) begin
      if (req0_valid_i && req1_valid_i) begin
        gnt0_o = last_q;
        gnt1_o = ~last_q;
      end else begin
        gnt0_o = req0_valid_i;
        gnt1_o = req1_valid_i;
      end
    end
    last_d = last_q;
    if (gnt0_o) begin
      last_d = 1'b0;
    end else if (gnt1_o) begin
      last_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

endmodule

// File: rtl/dual_stack_sched.sv
// Two-requester command scheduler driving the dual_stack control strobes.
// Build option: DUAL_STACK_SCHED_FIXED_PRIO_EN (fixed priority arbitration in the arbiter).
module dual_stack_sched #(
  parameter int RD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic       req0_op,
  input  logic       req0_sel,
  input  logic [7:0] req0_data,
  output logic       rsp0_valid,
  input  logic       rsp0_ready,
  output logic [7:0] rsp0_data,
  output logic       rsp0_err,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic       req1_op,
  input  logic       req1_sel,
  input  logic [7:0] req1_data,
  output logic       rsp1_valid,
  input  logic       rsp1_ready,
  output logic [7:0] rsp1_data,
  output logic       rsp1_err,
  output logic       ds_stack_select,
  output logic       ds_push,
  output logic       ds_pop,
  output logic [7:0] ds_data_in,
  input  logic [7:0] ds_data_out,
  input  logic       ds_s0_empty,
  input  logic       ds_s0_full,
  input  logic       ds_s1_empty,
  input  logic       ds_s1_full,
  output logic       busy
);
  import dual_stack_pkg::*;

  localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

  sched_state_t      state_q, state_d;
  logic              reqId_q, reqId_d;
  stack_op_t         op_q, op_d;
  logic              sel_q, sel_d;
  logic [DATA_W-1:0] wrData_q, wrData_d;
  logic [DATA_W-1:0] rdData_q, rdData_d;
  logic              err_q, err_d;
  logic [2:0]        waitCnt_q, waitCnt_d;

  logic gnt0, gnt1, flagHit, rspHs, inIdle;

  assign inIdle = (state_q == IDLE);

  dual_stack_sched_arb u_arb (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_i         (inIdle),
    .req0_valid_i (req0_valid),
    .req1_valid_i (req1_valid),
    .gnt0_o       (gnt0),
    .gnt1_o       (gnt1)
  );

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // Flag of the latched stack that would make the latched op illegal.
  assign flagHit = (op_q == PUSH) ? (sel_q ? ds_s1_full  : ds_s0_full)
                                  : (sel_q ? ds_s1_empty : ds_s0_empty);

  assign rspHs = (state_q == RESP) && (reqId_q ? rsp1_ready : rsp0_ready);

  always_comb begin
    state_d   = state_q;
    reqId_d   = reqId_q;
    op_d      = op_q;
    sel_d     = sel_q;
    wrData_d  = wrData_q;
    rdData_d  = rdData_q;
    err_d     = err_q;
    waitCnt_d = waitCnt_q;
    ds_push   = 1'b0;
    ds_pop    = 1'b0;

    case (state_q)
      IDLE: begin
        if (gnt0 || gnt1) begin
          reqId_d   = gnt1;
          op_d      = gnt1 ? stack_op_t'(req1_op) : stack_op_t'(req0_op);
          sel_d     = gnt1 ? req1_sel  : req0_sel;
          wrData_d  = gnt1 ? req1_data : req0_data;
          rdData_d  = '0;
          err_d     = 1'b0;
          waitCnt_d = '0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (flagHit) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else if (op_q == PUSH) begin
          ds_push = 1'b1;
          state_d = RESP;
        end else begin
          ds_pop  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (waitCnt_q == LAT_LAST) begin
          rdData_d = ds_data_out;
          state_d  = RESP;
        end else begin
          waitCnt_d = waitCnt_q + 3'd1;
        end
      end
      RESP: begin
        if (rspHs) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      reqId_q   <= 1'b0;
      op_q      <= POP;
      sel_q     <= 1'b0;
      wrData_q  <= '0;
      rdData_q  <= '0;
      err_q     <= 1'b0;
      waitCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      reqId_q   <= reqId_d;
      op_q      <= op_d;
      sel_q     <= sel_d;
      wrData_q  <= wrData_d;
      rdData_q  <= rdData_d;
      err_q     <= err_d;
      waitCnt_q <= waitCnt_d;
    end
  end

  // The stack address and write data are only presented while a command is in flight.
  assign ds_stack_select = ((state_q == ISSUE) || (state_q == WAIT)) ? sel_q : 1'b0;
  assign ds_data_in      = ((state_q == ISSUE) || (state_q == WAIT)) ? wrData_q : '0;

  assign rsp0_valid = (state_q == RESP) && !reqId_q;
  assign rsp1_valid = (state_q == RESP) &&  reqId_q;
  assign rsp0_data  = rsp0_valid ? rdData_q : '0;
  assign rsp1_data  = rsp1_valid ? rdData_q : '0;
  assign rsp0_err   = rsp0_valid & err_q;
  assign rsp1_err   = rsp1_valid & err_q;

  assign busy = !inIdle;

endmodule

// File: tb/tb_dual_stack_sched.sv
// Self-checking bench for dual_stack_sched with a behavioural dual stack and a response scoreboard.
module tb_dual_stack_sched;

  localparam int RD_LAT = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req0_op = 1'b0, req0_sel = 1'b0;
  logic [7:0] req0_data = 8'h00;
  logic       req1_valid = 1'b0, req1_op = 1'b0, req1_sel = 1'b0;
  logic [7:0] req1_data = 8'h00;
  logic       rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [7:0] rsp0_data, rsp1_data, ds_data_in, ds_data_out;
  logic       ds_stack_select, ds_push, ds_pop, busy;
  logic       ds_s0_empty, ds_s0_full, ds_s1_empty, ds_s1_full;

  always #5 clk = ~clk;

  dual_stack_sched #(.RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_sel(req0_sel), .req0_data(req0_data),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_sel(req1_sel), .req1_data(req1_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
    .ds_stack_select(ds_stack_select), .ds_push(ds_push), .ds_pop(ds_pop),
    .ds_data_in(ds_data_in), .ds_data_out(ds_data_out),
    .ds_s0_empty(ds_s0_empty), .ds_s0_full(ds_s0_full),
    .ds_s1_empty(ds_s1_empty), .ds_s1_full(ds_s1_full),
    .busy(busy)
  );

  // Behavioural dual stack: 16 words each, pop data appears RD_LAT cycles after the strobe.
  logic [7:0] mem [2][16];
  int         depth [2] = '{0, 0};
  logic [7:0] pipe [RD_LAT];

  always @(posedge clk) begin
    if (ds_push && depth[ds_stack_select] < 16) begin
      mem[ds_stack_select][depth[ds_stack_select]] <= ds_data_in;
      depth[ds_stack_select] <= depth[ds_stack_select] + 1;
    end
    pipe[0] <= 8'h00;
    if (ds_pop && depth[ds_stack_select] > 0) begin
      pipe[0] <= mem[ds_stack_select][depth[ds_stack_select] - 1];
      depth[ds_stack_select] <= depth[ds_stack_select] - 1;
    end
    for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
  end

  assign ds_data_out = pipe[RD_LAT-1];
  assign ds_s0_empty = (depth[0] == 0);
  assign ds_s0_full  = (depth[0] == 16);
  assign ds_s1_empty = (depth[1] == 0);
  assign ds_s1_full  = (depth[1] == 16);

  // Reference contents and scoreboard of expected responses.
  typedef struct {
    logic       id;
    logic [7:0] data;
    logic       err;
    int         lat;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] ref0[$];
  logic [7:0] ref1[$];
  logic       lastGrant = 1'b1;
  int         nAssert = 0;
  int         nFail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) check("push_pop_exclusive", {63'd0, ds_push & ds_pop}, 64'd0);

  function automatic logic [63:0] allOuts();
    return {30'd0, req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_data, rsp1_data,
            rsp0_err, rsp1_err, ds_stack_select, ds_push, ds_pop, ds_data_in, busy};
  endfunction

  function automatic logic rspV(input logic id);
    return id ? rsp1_valid : rsp0_valid;
  endfunction
  function automatic logic [7:0] rspD(input logic id);
    return id ? rsp1_data : rsp0_data;
  endfunction
  function automatic logic rspE(input logic id);
    return id ? rsp1_err : rsp0_err;
  endfunction

  task automatic driveReq(input logic id, input logic op, input logic sel, input logic [7:0] data);
    if (id) begin
      req1_valid = 1'b1; req1_op = op; req1_sel = sel; req1_data = data;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_sel = sel; req0_data = data;
    end
  endtask

  task automatic dropReq(input logic id);
    if (id) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
  endtask

  task automatic setRspReady(input logic id, input logic v);
    if (id) rsp1_ready = v;
    else    rsp0_ready = v;
  endtask

  task automatic waitGrant(output logic ok, output logic gid);
    ok = 1'b0;
    gid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (req0_ready || req1_ready) begin
        check("single_ready", {63'd0, req0_ready & req1_ready}, 64'd0);
        ok = 1'b1;
        gid = req1_ready;
        lastGrant = req1_ready;
        break;
      end
      @(negedge clk);
    end
    check("grant_seen", {63'd0, ok}, 64'd1);
  endtask

  // Waits for the oldest scoreboard response, checks latency/contents, then consumes it.
  task automatic checkOutput(input int hold);
    exp_t e;
    int   n;
    e = sbq.pop_front();
    n = 1;
    do begin
      @(negedge clk);
      #1;
      n++;
      if (n == 2) check("strobe_one_cycle", {62'd0, ds_push, ds_pop}, 64'd0);
    end while (!rspV(e.id) && n < 40);
    check("rsp_latency", 64'(n), 64'(e.lat));
    check("rsp_valid", {63'd0, rspV(e.id)}, 64'd1);
    check("rsp_other_idle", {63'd0, rspV(~e.id)}, 64'd0);
    check("rsp_data", {56'd0, rspD(e.id)}, {56'd0, e.data});
    check("rsp_err", {63'd0, rspE(e.id)}, {63'd0, e.err});
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      #1;
      check("rsp_hold", {54'd0, rspV(e.id), rspD(e.id), rspE(e.id)}, {54'd0, 1'b1, e.data, e.err});
    end
    setRspReady(e.id, 1'b1);
    @(negedge clk);
    #1;
    check("idle_after_rsp", {62'd0, busy, rspV(e.id)}, 64'd0);
    setRspReady(e.id, 1'b0);
  endtask

  // Called in the handshake cycle: records the expectation, checks the ISSUE cycle, then the response.
  task automatic issueAndRespond(input logic gid, input logic op, input logic sel,
                                 input logic [7:0] data, input int hold);
    exp_t e;
    int   sz;
    e.id = gid; e.data = 8'h00; e.err = 1'b0; e.lat = 2;
    sz = sel ? ref1.size() : ref0.size();
    if (op) begin
      if (sz >= 16) e.err = 1'b1;
      else if (sel) ref1.push_back(data);
      else ref0.push_back(data);
    end else begin
      if (sz == 0) e.err = 1'b1;
      else begin
        e.data = sel ? ref1.pop_back() : ref0.pop_back();
        e.lat = 2 + RD_LAT;
      end
    end
    sbq.push_back(e);
    @(negedge clk);
    dropReq(gid);
    #1;
    check("issue_push", {63'd0, ds_push}, {63'd0, op & ~e.err});
    check("issue_pop", {63'd0, ds_pop}, {63'd0, ~op & ~e.err});
    check("issue_sel", {63'd0, ds_stack_select}, {63'd0, sel});
    check("issue_data_in", {56'd0, ds_data_in}, {56'd0, data});
    check("issue_busy", {63'd0, busy}, 64'd1);
    checkOutput(hold);
  endtask

  task automatic applyStimulus(input logic id, input logic op, input logic sel,
                               input logic [7:0] data, input int hold);
    logic ok, gid;
    driveReq(id, op, sel, data);
    waitGrant(ok, gid);
    if (!ok) begin
      dropReq(id);
      return;
    end
    check("grant_id", {63'd0, gid}, {63'd0, id});
    issueAndRespond(gid, op, sel, data, hold);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic ok, gid, expW;
    logic [7:0] d0, d1;

    repeat (2) @(negedge clk);
    check("reset_outputs", allOuts(), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] push A5 to stack 0 from req0");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'hA5, 0);

    $display("[TB] pop stack 0 from req1 with response held off");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 4);

    $display("[TB] pop empty stack 1");
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 0);

    $display("[TB] fill stack 0 then overflow");
    for (int i = 0; i < 17; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'(8'h10 + i), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 0);

    $display("[TB] reset during WAIT");
    driveReq(1'b1, 1'b0, 1'b0, 8'h00);
    waitGrant(ok, gid);
    if (ok) begin
      check("rst_grant_id", {63'd0, gid}, 64'd1);
      void'(ref0.pop_back());
      @(negedge clk);
      dropReq(1'b1);
      #1;
      check("rst_issue_pop", {63'd0, ds_pop}, 64'd1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid_outputs", allOuts(), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      lastGrant = 1'b1;
    end else begin
      dropReq(1'b1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 0);

    $display("[TB] both requesters continuously valid");
    for (int i = 0; i < 4; i++) begin
      d0 = 8'(8'hC0 + i);
      d1 = 8'(8'hD0 + i);
`ifdef DUAL_STACK_SCHED_FIXED_PRIO_EN
      expW = 1'b0;
`else
      expW = ~lastGrant;
`endif
      driveReq(1'b0, 1'b1, 1'b1, d0);
      driveReq(1'b1, 1'b1, 1'b1, d1);
      waitGrant(ok, gid);
      if (!ok) break;
      check("rr_grant", {63'd0, gid}, {63'd0, expW});
      issueAndRespond(gid, 1'b1, 1'b1, gid ? d1 : d0, 0);
    end
    dropReq(1'b0);
    dropReq(1'b1);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h00, 1);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule

// File: doc/dual_stack_sched.md
# dual_stack_sched

Two-requester scheduler in front of `dual_stack`. It arbitrates push and pop commands from two independent clients, checks the target stack's full/empty flag before striking, and drives the single-cycle `push`/`pop` strobes and `stack_select`. It captures popped data after a fixed read latency and returns one response per accepted command. It is the only driver of the `dual_stack` control inputs.

## Interface
Parameters:
- `RD_LAT`, default 1: cycles from the `ds_pop` strobe to valid `ds_data_out`. Legal range 1..7.

Ports (N ∈ {0,1}; one set per requester):
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `reqN_valid`  in  1  command offered.
- `reqN_ready`  out  1  command accepted this cycle when high together with `reqN_valid`.
- `reqN_op`  in  1  1 = push, 0 = pop.
- `reqN_sel`  in  1  target stack (0 or 1).
- `reqN_data`  in  8  push data; ignored for pop.
- `rspN_valid`  out  1  response pending.
- `rspN_ready`  in  1  response consumed.
- `rspN_data`  out  8  popped value; 0 for a push or an error.
- `rspN_err`  out  1  push to a full stack or pop from an empty stack.
- `ds_stack_select`  out  1  to `dual_stack.stack_select`.
- `ds_push`, `ds_pop`  out  1  single-cycle strobes.
- `ds_data_in`  out  8  to `dual_stack.data_in`.
- `ds_data_out`  in  8  from `dual_stack.data_out`.
- `ds_s0_empty`, `ds_s0_full`, `ds_s1_empty`, `ds_s1_full`  in  1  stack flags.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- The FSM states are IDLE, ISSUE, WAIT and RESP. Only one command is in flight at a time.
- IDLE: the arbiter picks one valid requester, and only that requester's `reqN_ready` is high (combinational from the valid inputs). On the handshake the block latches the requester id, op, sel and data, then moves to ISSUE.
- ISSUE (1 cycle): the block checks the flag of the latched stack.
  - Error condition (push with full=1, or pop with empty=1): no strobe; err is latched; go to RESP.
  - Push, no error: `ds_push`=1; go to RESP.
  - Pop, no error: `ds_pop`=1; go to WAIT.
- WAIT: lasts `RD_LAT` cycles. `ds_data_out` is captured on the last WAIT cycle, then the FSM moves to RESP.
- RESP: `rspN_valid`=1 for the latched requester only. Data and err are held stable until `rspN_ready`. On the handshake the FSM returns to IDLE; the next request cannot be accepted before the following cycle.
- `ds_stack_select` and `ds_data_in` present the latched sel and data from ISSUE through WAIT. They are 0 in IDLE.
- Arbitration uses a last-grant pointer, which updates only on a request handshake. The reset value of the pointer gives requester 0 first win when both requesters are valid.
- Requests from the other requester wait, with `reqN_ready`=0, while the FSM is not in IDLE.

## Timing
- Reset values: every output is 0 (`reqN_ready`, `rspN_*`, `ds_*`, `busy`). The FSM is in IDLE and the pointer points at requester 1, so requester 0 wins first.
- Reset is asynchronous. Asserting `rst_n` mid-operation aborts the command with no response. Strobes drop immediately; a strobe that already fired is not undone.
- With the request handshake at cycle T:
  - ISSUE is cycle T+1.
  - Push or error: `rspN_valid` at T+2.
  - Pop: `rspN_valid` at T+2+`RD_LAT`.
- Each strobe is high for exactly one cycle per command. `ds_push` and `ds_pop` are never high together.
- Flags are sampled in ISSUE, not at acceptance.
- Back-to-back: with `rspN_ready` held at 1, one push completes every 3 cycles.

## Configuration
- `DUAL_STACK_SCHED_FIXED_PRIO_EN`
  - Defined: requester 0 always wins ties; the pointer logic is removed.
  - Undefined (default): two-way round-robin as described above.

## Structure
- Shared package `dual_stack_pkg`:
  - `sched_state_t` enum (IDLE, ISSUE, WAIT, RESP).
  - `stack_op_t` (POP=0, PUSH=1).
  - `STACK_WORDS`=16.
  - `DATA_W`=8.
- Sub-module `dual_stack_sched_arb`: combinational two-way grant plus the pointer register. Its grant logic is selected by the macro.

## Test plan
- After reset, push 0xA5 to stack 0 from req0 → `ds_push` at T+1, `ds_stack_select`=0, `ds_data_in`=0xA5; `rsp0_valid` at T+2 with err=0.
- Pop stack 0 from req1 with `RD_LAT`=3 → `ds_pop` at T+1; `rsp1_data`=0xA5 at T+5 with err=0; `rsp1_valid` is held while `rsp1_ready`=0 for 4 cycles.
- Pop an empty stack 1 → no `ds_pop`; `rspN_err`=1 and data=0 at T+2.
- Push 16 values then a 17th push to stack 0 → 17th response has err=1 and no strobe.
- Both requesters continuously valid, round-robin build → grants alternate 0,1,0,1; with the macro defined → all grants go to req0.
- Assert `rst_n` low during WAIT → all outputs 0 immediately; after release, a new command completes normally.
